// File: rtl/mips_pkg.sv
// Shared constants and types for the mips instruction-fetch stage.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam int          PC_STEP     = 4;
   localparam int          COUNT_WIDTH = 32;

   // IF/ID occupancy; the encoding is exactly the if_valid bit.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } fetch_state_e;

endpackage : mips_pkg

// File: rtl/mips_pcgen.sv
// PC register with next-PC selection (redirect > stall > sequential step).
// Redirect targets are forced onto a word boundary.
module mips_pcgen
   import mips_pkg::*;
#(
   parameter int                        INST_BUS_WIDTH = 17,
   parameter logic [INST_BUS_WIDTH-1:0] RESET_PC       = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      stall_i,
   input  logic                      redirect_i,
   input  logic [INST_BUS_WIDTH-1:0] redirect_pc_i,
   output logic [INST_BUS_WIDTH-1:0] pc_o,
   output logic [INST_BUS_WIDTH-1:0] pc4_o
);

   localparam logic [INST_BUS_WIDTH-1:0] ALIGN_MASK = INST_BUS_WIDTH'(3);
   localparam logic [INST_BUS_WIDTH-1:0] PC_RESET   = RESET_PC & ~ALIGN_MASK;

   logic [INST_BUS_WIDTH-1:0] pc_q;
   logic [INST_BUS_WIDTH-1:0] pc_d;

   // Natural truncation gives the 1FFFC -> 00000 wrap.
   assign pc4_o = pc_q + INST_BUS_WIDTH'(PC_STEP);
   assign pc_o  = pc_q;

   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = redirect_pc_i & ~ALIGN_MASK;
      end else if (!stall_i) begin
         pc_d = pc4_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule : mips_pcgen

// File: rtl/mips_ifetch.sv
// Instruction-fetch stage: drives instrom from the PC and captures the IF/ID register.
//   state | meaning
//   EMPTY | IF/ID holds a NOP bubble (after reset or a redirect flush)
//   FULL  | IF/ID holds the word fetched from if_pc
module mips_ifetch
   import mips_pkg::*;
#(
   parameter int                        DATA_WIDTH     = 32,
   parameter int                        INST_BUS_WIDTH = 17,
   parameter logic [INST_BUS_WIDTH-1:0] RESET_PC       = '0
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic [DATA_WIDTH-1:0]     imemrd_i,
   input  logic                      stall_i,
   input  logic                      redirect_i,
   input  logic [INST_BUS_WIDTH-1:0] redirect_pc_i,
   output logic [INST_BUS_WIDTH-1:0] iadr_o,
   output logic [DATA_WIDTH-1:0]     if_instr_o,
   output logic [INST_BUS_WIDTH-1:0] if_pc_o,
   output logic [INST_BUS_WIDTH-1:0] if_pc4_o,
   output logic                      if_valid_o,
   output logic [COUNT_WIDTH-1:0]    fetch_count_o
);

   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

   logic [INST_BUS_WIDTH-1:0] pc;
   logic [INST_BUS_WIDTH-1:0] pc4;

   fetch_state_e              state_q,  state_d;
   logic [DATA_WIDTH-1:0]     instr_q,  instr_d;
   logic [INST_BUS_WIDTH-1:0] ifpc_q,   ifpc_d;
   logic [INST_BUS_WIDTH-1:0] ifpc4_q,  ifpc4_d;
   logic [COUNT_WIDTH-1:0]    count_q,  count_d;

   mips_pcgen #(
      .INST_BUS_WIDTH (INST_BUS_WIDTH),
      .RESET_PC       (RESET_PC)
   ) u_pcgen (
      .clk_i         (clk_i),
      .rst_n_i       (reset_n_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .pc_o          (pc),
      .pc4_o         (pc4)
   );

   // A flush leaves if_pc/if_pc4 pointing at the last real fetch.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      ifpc4_d = ifpc4_q;
      count_d = count_q;
      if (redirect_i) begin
         state_d = EMPTY;
         instr_d = NOP;
      end else if (!stall_i) begin
         state_d = FULL;
         instr_d = imemrd_i;
         ifpc_d  = pc;
         ifpc4_d = pc4;
         if (count_q != '1) begin
            count_d = count_q + COUNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= EMPTY;
         instr_q <= NOP;
         ifpc_q  <= '0;
         ifpc4_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         ifpc4_q <= ifpc4_d;
         count_q <= count_d;
      end
   end

   assign iadr_o        = pc;
   assign if_instr_o    = instr_q;
   assign if_pc_o       = ifpc_q;
   assign if_pc4_o      = ifpc4_q;
   assign if_valid_o    = (state_q == FULL);
   assign fetch_count_o = count_q;

endmodule : mips_ifetch

// File: tb/tb_mips_ifetch.sv
// Self-checking bench for mips_ifetch: directed vector table, async reset and
// randomized stall/redirect traffic against a behavioural fetch model.
module tb_mips_ifetch;

   logic        clk;
   logic        reset_n;
   logic [31:0] imemrd;
   logic        stall;
   logic        redirect;
   logic [16:0] redirect_pc;
   logic [16:0] iadr;
   logic [31:0] if_instr;
   logic [16:0] if_pc;
   logic [16:0] if_pc4;
   logic        if_valid;
   logic [31:0] fetch_count;

   int n_cmp = 0;
   int n_bad = 0;

   mips_ifetch dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .imemrd_i      (imemrd),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .iadr_o        (iadr),
      .if_instr_o    (if_instr),
      .if_pc_o       (if_pc),
      .if_pc4_o      (if_pc4),
      .if_valid_o    (if_valid),
      .fetch_count_o (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instrom model: distinct word per address.
   function automatic logic [31:0] rom(input logic [16:0] a);
      if (a == 17'h0) return 32'h2008_0005;
      return ({15'h0, a} * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   assign imemrd = rom(iadr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        st;
      logic        rd;
      logic [16:0] rpc;
      logic [16:0] e_iadr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [16:0] e_pc;
      logic [16:0] e_pc4;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl [10];

   // Behavioural model state
   int unsigned m_pc, m_ifpc, m_ifpc4, m_cnt;
   logic        m_valid;
   logic [31:0] m_instr;

   task automatic model_reset();
      m_pc = 0; m_ifpc = 0; m_ifpc4 = 0; m_cnt = 0;
      m_valid = 1'b0; m_instr = 32'h0;
   endtask

   task automatic model_edge(input logic s, input logic r, input logic [16:0] rpc);
      if (r) begin
         m_pc    = {15'h0, rpc} & 32'h1FFFC;
         m_valid = 1'b0;
         m_instr = 32'h0;
      end else if (!s) begin
         m_instr = rom(m_pc[16:0]);
         m_ifpc  = m_pc;
         m_pc    = (m_pc + 4) % 32'h20000;
         m_ifpc4 = m_pc;
         m_valid = 1'b1;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".iadr"},     {15'h0, iadr},     m_pc);
      chk({tag, ".if_valid"}, {31'h0, if_valid}, {31'h0, m_valid});
      chk({tag, ".if_instr"}, if_instr,          m_instr);
      chk({tag, ".if_pc"},    {15'h0, if_pc},    m_ifpc);
      chk({tag, ".if_pc4"},   {15'h0, if_pc4},   m_ifpc4);
      chk({tag, ".count"},    fetch_count,       m_cnt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            st    rd    rpc       iadr      v     instr               pc        pc4       cnt
      tbl[0] = '{1'b0, 1'b0, 17'h0,     17'h00004, 1'b1, rom(17'h0),       17'h0,     17'h4,     32'd1};
      tbl[1] = '{1'b0, 1'b0, 17'h0,     17'h00008, 1'b1, rom(17'h4),       17'h4,     17'h8,     32'd2};
      tbl[2] = '{1'b1, 1'b0, 17'h0,     17'h00008, 1'b1, rom(17'h4),       17'h4,     17'h8,     32'd2};
      tbl[3] = '{1'b1, 1'b0, 17'h0,     17'h00008, 1'b1, rom(17'h4),       17'h4,     17'h8,     32'd2};
      tbl[4] = '{1'b1, 1'b0, 17'h0,     17'h00008, 1'b1, rom(17'h4),       17'h4,     17'h8,     32'd2};
      tbl[5] = '{1'b0, 1'b0, 17'h0,     17'h0000C, 1'b1, rom(17'h8),       17'h8,     17'hC,     32'd3};
      tbl[6] = '{1'b1, 1'b1, 17'h00103, 17'h00100, 1'b0, 32'h0,            17'h8,     17'hC,     32'd3};
      tbl[7] = '{1'b0, 1'b0, 17'h0,     17'h00104, 1'b1, rom(17'h100),     17'h100,   17'h104,   32'd4};
      tbl[8] = '{1'b0, 1'b1, 17'h1FFFC, 17'h1FFFC, 1'b0, 32'h0,            17'h100,   17'h104,   32'd4};
      tbl[9] = '{1'b0, 1'b0, 17'h0,     17'h00000, 1'b1, rom(17'h1FFFC),   17'h1FFFC, 17'h0,     32'd5};

      reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      repeat (3) @(negedge clk);
      chk("rst.iadr",     {15'h0, iadr}, 32'h0);
      chk("rst.if_valid", {31'h0, if_valid}, 32'h0);
      chk("rst.if_instr", if_instr, 32'h0);
      chk("rst.count",    fetch_count, 32'h0);
      reset_n = 1'b1;
      #1;
      chk("rel.iadr",     {15'h0, iadr}, 32'h0);
      chk("rel.if_valid", {31'h0, if_valid}, 32'h0);

      for (int i = 0; i < 10; i++) begin
         stall = tbl[i].st; redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
         @(negedge clk);
         chk($sformatf("vec%0d.iadr", i),     {15'h0, iadr},     {15'h0, tbl[i].e_iadr});
         chk($sformatf("vec%0d.if_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].e_valid});
         chk($sformatf("vec%0d.if_instr", i), if_instr,          tbl[i].e_instr);
         chk($sformatf("vec%0d.if_pc", i),    {15'h0, if_pc},    {15'h0, tbl[i].e_pc});
         chk($sformatf("vec%0d.if_pc4", i),   {15'h0, if_pc4},   {15'h0, tbl[i].e_pc4});
         chk($sformatf("vec%0d.count", i),    fetch_count,       tbl[i].e_cnt);
      end

      // Asynchronous reset mid-run with a redirect pending: takes effect before any edge.
      stall = 1'b0; redirect = 1'b0;
      repeat (2) @(negedge clk);
      redirect = 1'b1; redirect_pc = 17'h00440; stall = 1'b1;
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("async.iadr",     {15'h0, iadr}, 32'h0);
      chk("async.if_valid", {31'h0, if_valid}, 32'h0);
      chk("async.if_instr", if_instr, 32'h0);
      chk("async.count",    fetch_count, 32'h0);
      @(negedge clk);
      redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
      reset_n = 1'b1;
      model_reset();

      for (int c = 0; c < 3000; c++) begin
         chk_model($sformatf("rnd%0d", c));
         stall    = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0)
            redirect_pc = 17'h1FFF0 | 17'($urandom_range(0, 15));
         else
            redirect_pc = 17'($urandom);
         model_edge(stall, redirect, redirect_pc);
         @(negedge clk);
      end
      chk_model("rnd_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mips_ifetch
